// File: rtl/mul_dispatch_pkg.sv
// mul_dispatch_pkg: shared defaults and FSM state type for the multiply dispatcher.
//   OPW_DEFAULT   default operand width
//   DEPTH_DEFAULT default operand FIFO depth (power of 2, 2..16)
//   RESW_DEFAULT  product width for the default operand width
//   state_e       dispatcher FSM states
package mul_dispatch_pkg;

  localparam int unsigned OPW_DEFAULT   = 8;
  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam int unsigned RESW_DEFAULT  = 2 * OPW_DEFAULT;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StHold
  } state_e;

endpackage

// File: rtl/mul_op_fifo.sv
// mul_op_fifo: synchronous FIFO holding operand pairs waiting for the multiplier.
//   clock    system clock (rising edge)
//   reset    synchronous active-high reset, empties the FIFO
//   i_push   write request (ignored when full)
//   i_pop    read request (ignored when empty)
//   i_wdata  data written on push
//   o_rdata  head-of-queue data (valid when not empty)
//   o_full   level == DEPTH
//   o_empty  level == 0
//   o_level  current occupancy
module mul_op_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 16,
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];

  // Full blocks pushes even if a pop happens in the same cycle.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      // DEPTH is a power of 2, so pointer overflow is the modulo wrap.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/mul_dispatch.sv
// mul_dispatch: queues operand pairs and feeds them one at a time to an external
// radix-4 multiplier, returning each product through a valid/ready output.
//   clock, reset            clock and synchronous active-high reset
//   in_valid/in_ready       operand pair handshake; in_x multiplicand, in_y multiplier
//   mul_start               one-cycle start pulse to the multiplier
//   mul_x, mul_y            operands, stable from ISSUE until back in IDLE
//   mul_result, mul_ready   product and done level from the multiplier
//   out_valid/out_ready     product handshake; out_result is the captured product
//   level                   operand FIFO occupancy
module mul_dispatch
  import mul_dispatch_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned OPW   = OPW_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPW-1:0]           in_x,
  input  logic [OPW-1:0]           in_y,
  output logic                     mul_start,
  output logic [OPW-1:0]           mul_x,
  output logic [OPW-1:0]           mul_y,
  input  logic [2*OPW-1:0]         mul_result,
  input  logic                     mul_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*OPW-1:0]         out_result,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned RESW = 2 * OPW;
  localparam int unsigned LW   = $clog2(DEPTH) + 1;

  state_e            r_state;
  state_e            w_state_d;
  logic [OPW-1:0]    r_mul_x;
  logic [OPW-1:0]    r_mul_y;
  logic [RESW-1:0]   r_out_result;
  logic              r_out_valid;
  logic              r_rdy_prev;
  logic              w_push;
  logic              w_pop;
  logic              w_capture;
  logic              w_release;
  logic              w_full;
  logic              w_empty;
  logic [2*OPW-1:0]  w_rdata;
  logic [LW-1:0]     w_level;

  assign in_ready   = ~w_full;
  assign w_push     = in_valid & in_ready;
  assign mul_x      = r_mul_x;
  assign mul_y      = r_mul_y;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign level      = w_level;

  mul_op_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * OPW),
    .LW    (LW)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({in_x, in_y}),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (!w_empty) w_state_d = StIssue;
      StIssue: w_state_d = StWait;
      StWait:  if (w_capture) w_state_d = StHold;
      StHold:  if (out_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs and datapath enables.
  always_comb begin
    mul_start = 1'b0;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_release = 1'b0;
    unique case (r_state)
      StIdle:  w_pop     = ~w_empty;
      StIssue: mul_start = 1'b1;
      // Only a fresh rise counts; a done level left over from the previous
      // operation was already sampled into r_rdy_prev during ISSUE.
      StWait:  w_capture = mul_ready & ~r_rdy_prev;
      StHold:  w_release = out_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mul_x      <= '0;
      r_mul_y      <= '0;
      r_out_result <= '0;
      r_out_valid  <= 1'b0;
      r_rdy_prev   <= 1'b0;
    end else begin
      r_rdy_prev <= mul_ready;
      if (w_pop) begin
        r_mul_x <= w_rdata[2*OPW-1:OPW];
        r_mul_y <= w_rdata[OPW-1:0];
      end
      if (w_capture) begin
        r_out_result <= mul_result;
        r_out_valid  <= 1'b1;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule
